// File: rtl/regfile_pkg.sv
// Shared constants and writeback request type for the register-file writeback path.
package regfile_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NREGS      = 32;

   localparam int unsigned REQ_ALU = 0;
   localparam int unsigned REQ_LSU = 1;
   localparam int unsigned REQ_CSR = 2;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wbReq_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer, pointer moves past the
// winner on each completed handshake.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 3
) (
   input  logic               iCLK,
   input  logic               iRST_N,
   input  logic [NUM_REQ-1:0] iREQ,
   input  logic               iADVANCE,
   output logic [NUM_REQ-1:0] oGRANT
);

   localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PtrW-1:0] ptrQ;
   logic [PtrW-1:0] winner;
   int unsigned     idx;

   // Walk the search order backwards so the earliest requester is the last to assign.
   always_comb begin
      oGRANT = '0;
      winner = '0;
      idx    = 0;
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
         idx = (int'(ptrQ) + i) % NUM_REQ;
         if (iREQ[idx]) begin
            oGRANT      = '0;
            oGRANT[idx] = 1'b1;
            winner      = PtrW'(idx);
         end
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         ptrQ <= '0;
      end else if (iADVANCE) begin
         ptrQ <= (winner == PtrW'(NUM_REQ - 1)) ? '0 : winner + PtrW'(1);
      end
   end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: round-robin write-port sharing, registered write stage
// and RAW scoreboard. Define WB_BYPASS_EN to add writeback-cycle forwarding outputs.
module regfile_wb_scheduler #(
   parameter int unsigned NUM_REQ    = 3,
   parameter int unsigned XLEN       = regfile_pkg::XLEN,
   parameter int unsigned REG_ADDR_W = regfile_pkg::REG_ADDR_W
) (
   input  logic                          iCLK,
   input  logic                          iRST_N,
   input  logic [NUM_REQ-1:0]            iREQ_VALID,
   output logic [NUM_REQ-1:0]            oREQ_READY,
   input  logic [NUM_REQ*REG_ADDR_W-1:0] iREQ_RD,
   input  logic [NUM_REQ*XLEN-1:0]       iREQ_DATA,
   output logic                          oDONE,
   output logic [REG_ADDR_W-1:0]         oRD,
   output logic [XLEN-1:0]               oWB_DATA,
   input  logic                          iISSUE,
   input  logic [REG_ADDR_W-1:0]         iISSUE_RD,
   input  logic [REG_ADDR_W-1:0]         iRS1,
   input  logic [REG_ADDR_W-1:0]         iRS2,
   output logic                          oRS1_BUSY,
   output logic                          oRS2_BUSY
`ifdef WB_BYPASS_EN
   ,
   output logic                          oRS1_FWD,
   output logic                          oRS2_FWD,
   output logic [XLEN-1:0]               oFWD_DATA
`endif
);

   import regfile_pkg::*;

   wbReq_t             reqs [NUM_REQ];
   wbReq_t             winReq;
   logic [NUM_REQ-1:0] grant;
   logic               handshake;
   logic               doneQ;
   logic [REG_ADDR_W-1:0] rdQ;
   logic [XLEN-1:0]    dataQ;
   logic [NREGS-1:0]   busyQ;
   logic [NREGS-1:0]   busyD;

   always_comb begin
      winReq = '0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         reqs[k].valid = iREQ_VALID[k];
         reqs[k].rd    = iREQ_RD[k*REG_ADDR_W +: REG_ADDR_W];
         reqs[k].data  = iREQ_DATA[k*XLEN +: XLEN];
         if (grant[k]) winReq = reqs[k];
      end
   end

   // Grant only goes to a valid requester, so the winner's valid is the handshake.
   assign handshake  = winReq.valid;
   assign oREQ_READY = grant;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) uArb (
      .iCLK     (iCLK),
      .iRST_N   (iRST_N),
      .iREQ     (iREQ_VALID),
      .iADVANCE (handshake),
      .oGRANT   (grant)
   );

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         doneQ <= 1'b0;
         rdQ   <= '0;
         dataQ <= '0;
      end else begin
         doneQ <= handshake && (winReq.rd != '0);
         if (handshake && (winReq.rd != '0)) begin
            rdQ   <= winReq.rd;
            dataQ <= winReq.data;
         end
      end
   end

   // Set after clear: a newly issued producer outranks the write retiring this edge.
   always_comb begin
      busyD = busyQ;
      if (doneQ) busyD[rdQ] = 1'b0;
      if (iISSUE && (iISSUE_RD != '0)) busyD[iISSUE_RD] = 1'b1;
      busyD[0] = 1'b0;
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         busyQ <= '0;
      end else begin
         busyQ <= busyD;
      end
   end

   assign oDONE    = doneQ;
   assign oRD      = rdQ;
   assign oWB_DATA = dataQ;

`ifdef WB_BYPASS_EN
   assign oRS1_FWD  = doneQ && (rdQ == iRS1) && (iRS1 != '0);
   assign oRS2_FWD  = doneQ && (rdQ == iRS2) && (iRS2 != '0);
   assign oFWD_DATA = dataQ;
   assign oRS1_BUSY = busyQ[iRS1] && !oRS1_FWD;
   assign oRS2_BUSY = busyQ[iRS2] && !oRS2_FWD;
`else
   assign oRS1_BUSY = busyQ[iRS1];
   assign oRS2_BUSY = busyQ[iRS2];
`endif

endmodule
